// File: rtl/mio_timer_pkg.sv
// Shared register map, mode encodings and control-word field offsets for the
// three-channel MIO down-counter/timer.
package mio_timer_pkg;

   localparam logic [1:0] ADDR_CH0  = 2'd0;
   localparam logic [1:0] ADDR_CH1  = 2'd1;
   localparam logic [1:0] ADDR_CH2  = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   // Code 11 is reserved: it is stored and read back, but never counts.
   typedef enum logic [1:0] {
      MODE_STOP     = 2'b00,
      MODE_ONESHOT  = 2'b01,
      MODE_PERIODIC = 2'b10,
      MODE_RSVD     = 2'b11
   } mode_e;

   localparam int CTRL_MODE_LSB = 0;
   localparam int CTRL_IEN_LSB  = 8;
   localparam int CTRL_CLR_LSB  = 16;

   function automatic logic mode_runs(input mode_e m);
      return (m == MODE_ONESHOT) || (m == MODE_PERIODIC);
   endfunction

endpackage

// File: rtl/mio_timer_if.sv
// Counter-port slice of the MIO bus: write strobe, register select, write
// data and the combinational read-back path.
interface mio_timer_if #(parameter int WIDTH = 32);
   logic             counter_we;
   logic [1:0]       addr;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] counter_out;

   modport master (output counter_we, addr, data_in, input counter_out);
   modport slave  (input counter_we, addr, data_in, output counter_out);
endinterface

// File: rtl/mio_timer_channel.sv
// One down-counter channel: holds count and reload, steps on the shared tick
// edge and flags the terminal event plus a one-shot self-stop request.
module timer_channel
   import mio_timer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_edge_i,
   input  mode_e            mode_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] count_o,
   output logic             term_evt_o,
   output logic             stop_req_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             step;

   // A same-cycle register write suppresses the step entirely.
   always_comb begin
      step       = tick_edge_i && mode_runs(mode_i) && !wr_en_i;
      term_evt_o = step && (count_q == WIDTH'(1));
      stop_req_o = term_evt_o && (mode_i == MODE_ONESHOT);
      count_d    = count_q;
      reload_d   = reload_q;
      if (wr_en_i) begin
         count_d  = wr_data_i;
         reload_d = wr_data_i;
      end else if (term_evt_o) begin
         count_d = (mode_i == MODE_PERIODIC) ? reload_q : '0;
      end else if (step && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mio_timer.sv
// Three-channel memory-mapped timer: control/status register, tick edge
// detect, per-channel counters and the zero-latency read mux.
module mio_timer
   import mio_timer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cnt_tick,
   mio_timer_if.slave    bus,
   output logic [NCH-1:0] ch_out,
   output logic          irq
);

   logic                       tick_q;
   logic                       tick_edge;
   logic [NCH-1:0][1:0]        mode_q, mode_d;
   logic [NCH-1:0]             ien_q, ien_d;
   logic [NCH-1:0]             status_q, status_d;
   logic [NCH-1:0]             ch_we, term_evt, stop_req;
   logic [NCH-1:0][WIDTH-1:0]  count;
   logic                       ctrl_we;
   logic [WIDTH-1:0]           ctrl_rd;

   assign tick_edge = cnt_tick & ~tick_q;
   assign ctrl_we   = bus.counter_we && (bus.addr == ADDR_CTRL);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign ch_we[c] = bus.counter_we && (bus.addr == 2'(c));
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk         (clk),
         .rst         (rst),
         .tick_edge_i (tick_edge),
         .mode_i      (mode_e'(mode_q[c])),
         .wr_en_i     (ch_we[c]),
         .wr_data_i   (bus.data_in),
         .count_o     (count[c]),
         .term_evt_o  (term_evt[c]),
         .stop_req_o  (stop_req[c])
      );
   end

   // Self-stop first, then a control write overrides it; terminal events
   // are OR-ed in last so a set beats a simultaneous write-one-to-clear.
   always_comb begin
      mode_d   = mode_q;
      ien_d    = ien_q;
      status_d = status_q;
      for (int c = 0; c < NCH; c++)
         if (stop_req[c]) mode_d[c] = MODE_STOP;
      if (ctrl_we) begin
         mode_d   = bus.data_in[CTRL_MODE_LSB +: 2*NCH];
         ien_d    = bus.data_in[CTRL_IEN_LSB +: NCH];
         status_d = status_q & ~bus.data_in[CTRL_CLR_LSB +: NCH];
      end
      status_d = status_d | term_evt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q   <= 1'b0;
         mode_q   <= '0;
         ien_q    <= '0;
         status_q <= '0;
      end else begin
         tick_q   <= cnt_tick;
         mode_q   <= mode_d;
         ien_q    <= ien_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      ctrl_rd                                = '0;
      ctrl_rd[CTRL_MODE_LSB +: 2*NCH]        = mode_q;
      ctrl_rd[CTRL_IEN_LSB +: NCH]           = ien_q;
      ctrl_rd[CTRL_CLR_LSB +: NCH]           = status_q;
      unique case (bus.addr)
         ADDR_CH0: bus.counter_out = count[0];
         ADDR_CH1: bus.counter_out = count[1];
         ADDR_CH2: bus.counter_out = count[2];
         default:  bus.counter_out = ctrl_rd;
      endcase
   end

   assign ch_out = status_q;
   assign irq    = |(status_q & ien_q);

endmodule

// File: tb/tb_mio_timer.sv
// Directed scoreboard bench for mio_timer: expected values are queued as the
// stimulus is issued and popped when the corresponding output is sampled.
module tb_mio_timer;
   import mio_timer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cnt_tick = 1'b0;
   logic [2:0] ch_out;
   logic       irq;

   mio_timer_if #(.WIDTH(32)) bus ();

   mio_timer #(.WIDTH(32), .NCH(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .cnt_tick (cnt_tick),
      .bus      (bus),
      .ch_out   (ch_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_asrt = 0;
   int   n_fail = 0;

   task automatic expect_v(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_asrt++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: got %0h want queued entry", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.counter_we = 1'b1;
      bus.addr       = a;
      bus.data_in    = d;
      @(negedge clk);
      bus.counter_we = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      cnt_tick = 1'b1;
      @(negedge clk);
      cnt_tick = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] v, input string tag);
      @(negedge clk);
      bus.addr = a;
      expect_v(tag, v);
      #1 check(bus.counter_out);
   endtask

   task automatic chk_st(input logic [2:0] st, input logic ir, input string tag);
      expect_v({tag, "_ch_out"}, {29'b0, st});
      check({29'b0, ch_out});
      expect_v({tag, "_irq"}, {31'b0, ir});
      check({31'b0, irq});
   endtask

   initial begin
      bus.counter_we = 1'b0;
      bus.addr       = ADDR_CH0;
      bus.data_in    = '0;

      // reset state
      #2;
      expect_v("reset_out", 32'h0);
      check(bus.counter_out);
      chk_st(3'b000, 1'b0, "reset");
      @(negedge clk);
      rst = 1'b1;

      // one-shot channel 0
      wr(ADDR_CH0, 32'd3);
      wr(ADDR_CTRL, 32'h0000_0101);
      tick(); rd(ADDR_CH0, 32'd2, "os_t1");
      tick(); rd(ADDR_CH0, 32'd1, "os_t2");
      chk_st(3'b000, 1'b0, "os_t2");
      tick(); rd(ADDR_CH0, 32'd0, "os_t3");
      chk_st(3'b001, 1'b1, "os_t3");
      rd(ADDR_CTRL, 32'h0001_0100, "os_ctrl");
      tick(); rd(ADDR_CH0, 32'd0, "os_t4");

      wr(ADDR_CTRL, 32'h0001_0000);
      chk_st(3'b000, 1'b0, "os_clr");

      // periodic channel 1
      wr(ADDR_CH1, 32'd2);
      wr(ADDR_CTRL, 32'h0000_0008);
      tick(); rd(ADDR_CH1, 32'd1, "per_t1");
      chk_st(3'b000, 1'b0, "per_t1");
      tick(); rd(ADDR_CH1, 32'd2, "per_t2");
      chk_st(3'b010, 1'b0, "per_t2");
      wr(ADDR_CTRL, 32'h0002_0008);
      chk_st(3'b000, 1'b0, "per_clr");
      tick(); rd(ADDR_CH1, 32'd1, "per_t3");
      tick(); rd(ADDR_CH1, 32'd2, "per_t4");
      chk_st(3'b010, 1'b0, "per_t4");
      tick(); rd(ADDR_CH1, 32'd1, "per_t5");

      // write colliding with tick edge on ch2
      wr(ADDR_CH2, 32'd10);
      wr(ADDR_CTRL, 32'h0000_0020);
      tick(); rd(ADDR_CH2, 32'd9, "col_pre");
      @(negedge clk);
      cnt_tick = 1'b1; bus.counter_we = 1'b1; bus.addr = ADDR_CH2; bus.data_in = 32'd7;
      @(negedge clk);
      cnt_tick = 1'b0; bus.counter_we = 1'b0;
      rd(ADDR_CH2, 32'd7, "col_wr_wins");
      tick(); rd(ADDR_CH2, 32'd6, "col_post");

      // W1C colliding with ch0 terminal event
      wr(ADDR_CH0, 32'd1);
      wr(ADDR_CTRL, 32'h0000_0021);
      @(negedge clk);
      cnt_tick = 1'b1; bus.counter_we = 1'b1; bus.addr = ADDR_CTRL; bus.data_in = 32'h0001_0021;
      @(negedge clk);
      cnt_tick = 1'b0; bus.counter_we = 1'b0;
      chk_st(3'b011, 1'b0, "w1c_set_wins");
      rd(ADDR_CH0, 32'd0, "w1c_ch0");
      rd(ADDR_CH2, 32'd5, "w1c_ch2");

      // level held high: one step only
      wr(ADDR_CH2, 32'd5);
      @(negedge clk);
      cnt_tick = 1'b1;
      repeat (10) @(negedge clk);
      cnt_tick = 1'b0;
      rd(ADDR_CH2, 32'd4, "pace_hold");

      // zero reload in periodic mode is inert
      wr(ADDR_CH1, 32'd0);
      wr(ADDR_CTRL, 32'h0007_0008);
      tick(); tick(); tick();
      rd(ADDR_CH1, 32'd0, "zero_reload");
      chk_st(3'b000, 1'b0, "zero_reload");

      // read mux sweep, one address per cycle
      wr(ADDR_CH0, 32'h11);
      wr(ADDR_CH1, 32'h22);
      wr(ADDR_CH2, 32'h33);
      rd(ADDR_CH0,  32'h11, "mux0");
      rd(ADDR_CH1,  32'h22, "mux1");
      rd(ADDR_CH2,  32'h33, "mux2");
      rd(ADDR_CTRL, 32'h8,  "mux3");

      // reset mid-count
      wr(ADDR_CH0, 32'd1);
      wr(ADDR_CTRL, 32'h0000_0109);
      tick();
      chk_st(3'b001, 1'b1, "pre_rst");
      rd(ADDR_CH1, 32'h21, "pre_rst_ch1");
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      expect_v("rst_async_out", 32'h0);
      check(bus.counter_out);
      chk_st(3'b000, 1'b0, "rst_async");
      bus.addr = ADDR_CTRL;
      #1;
      expect_v("rst_async_ctrl", 32'h0);
      check(bus.counter_out);
      @(negedge clk);
      rst = 1'b1;
      tick();
      rd(ADDR_CH0, 32'd0, "post_rst_ch0");
      chk_st(3'b000, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
